// File: rtl/ps2_pkg.sv
// Shared PS/2 receive types and constants: receiver state, default tuning, scan-code markers.
// Pure declarations with no timing or flow-control behaviour of its own.
package ps2_pkg;

    localparam int PS2_FILTER_LEN_DEF = 8;
    localparam int PS2_TIMEOUT_DEF    = 100000;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^data ^ par;
    endfunction

endpackage

// File: rtl/ps2_frame_rx_if.sv
// Received-byte bus: data, one-cycle good/error strobes and busy flag.
// Strobe-only with no ready; the consumer must take every strobe.
interface ps2_frame_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       timeout_err;
    logic       busy;

    modport master (output rx_data, rx_valid, parity_err, frame_err, timeout_err, busy);
    modport slave  (input  rx_data, rx_valid, parity_err, frame_err, timeout_err, busy);
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus glitch filter for one PS/2 pin; output idles high.
// Latency pin to output is 2+FILTER_LEN cycles; no backpressure.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = PS2_FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic filt
);

    localparam logic [7:0] CNT_LAST = 8'(FILTER_LEN - 1);

    logic [1:0] sync_q, sync_d;
    logic       out_q, out_d;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        sync_d = {sync_q[0], pin};
        out_d  = out_q;
        cnt_d  = '0;
        // Count only an unbroken run of samples disagreeing with the output.
        if (sync_q[1] != out_q) begin
            if (cnt_q == CNT_LAST) begin
                out_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            out_q  <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt = out_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host deframer: filtered kclk falling edges clock start/8 data/parity/stop into a byte.
// Strobes one cycle after the stop-bit edge; no backpressure, one strobe per frame or timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = PS2_FILTER_LEN_DEF,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              kclk,
    input  logic              kdata,
    ps2_frame_rx_if.master    rx
);

    localparam int                TO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic kclk_f, kdata_f, fall;

    rx_state_e       state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            par_q, par_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            valid_q, valid_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic            terr_q, terr_d;
    logic            kclk_prev_q, kclk_prev_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (kclk),
        .filt  (kclk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (kdata),
        .filt  (kdata_f)
    );

    assign fall = kclk_prev_q & ~kclk_f;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        rx_data_d   = rx_data_q;
        valid_d     = 1'b0;
        perr_d      = 1'b0;
        ferr_d      = 1'b0;
        terr_d      = 1'b0;
        kclk_prev_d = kclk_f;
        to_cnt_d    = to_cnt_q;

        // A falling edge in the expiry cycle takes precedence over the timeout.
        if (state_q == RX_IDLE || fall) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
            to_cnt_d = '0;
            terr_d   = 1'b1;
            state_d  = RX_IDLE;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        if (fall) begin
            unique case (state_q)
                RX_IDLE: begin
                    if (!kdata_f) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                RX_DATA: begin
                    shreg_d   = {kdata_f, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                end
                RX_PARITY: begin
                    par_d   = kdata_f;
                    state_d = RX_STOP;
                end
                RX_STOP: begin
                    state_d = RX_IDLE;
                    if (!kdata_f) begin
                        ferr_d = 1'b1;
                    end else if (odd_parity_ok(shreg_q, par_q)) begin
                        rx_data_d = shreg_q;
                        valid_d   = 1'b1;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RX_IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            par_q       <= 1'b0;
            rx_data_q   <= 8'h00;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            terr_q      <= 1'b0;
            kclk_prev_q <= 1'b1;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            rx_data_q   <= rx_data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            terr_q      <= terr_d;
            kclk_prev_q <= kclk_prev_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign rx.rx_data     = rx_data_q;
    assign rx.rx_valid    = valid_q;
    assign rx.parity_err  = perr_q;
    assign rx.frame_err   = ferr_q;
    assign rx.timeout_err = terr_q;
    assign rx.busy        = (state_q != RX_IDLE);

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx with a short filter, short timeout and fast PS/2 clock.
// Good, bad-parity, bad-stop, bad-start, glitch, timeout and mid-frame reset cases.
module tb_ps2_frame_rx;

    localparam int FL = 4;
    localparam int TO = 300;
    localparam int HP = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic kclk = 1'b1;
    logic kdata = 1'b1;

    int checks = 0;
    int errors = 0;
    int n_valid = 0, n_perr = 0, n_ferr = 0, n_tout = 0;
    int e_valid = 0, e_perr = 0, e_ferr = 0, e_tout = 0;

    ps2_frame_rx_if rx ();

    ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kclk  (kclk),
        .kdata (kdata),
        .rx    (rx)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (rx.rx_valid)    n_valid++;
        if (rx.parity_err)  n_perr++;
        if (rx.frame_err)   n_ferr++;
        if (rx.timeout_err) n_tout++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, ".valid"}, n_valid, e_valid);
        chk({tag, ".perr"},  n_perr,  e_perr);
        chk({tag, ".ferr"},  n_ferr,  e_ferr);
        chk({tag, ".tout"},  n_tout,  e_tout);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        kdata = b;
        repeat (HP) @(negedge clk);
        kclk = 1'b0;
        repeat (HP) @(negedge clk);
        kclk = 1'b1;
    endtask

    task automatic glitch();
        repeat (HP) @(negedge clk);
        kclk = 1'b0;
        repeat (FL - 1) @(negedge clk);
        kclk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                              input int glitch_at);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(data[i]);
            if (i == glitch_at) glitch();
        end
        send_bit(par);
        send_bit(stop);
        repeat (HP) @(negedge clk);
        kdata = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.busy",  32'(rx.busy), 0);
        chk("rst.data",  32'(rx.rx_data), 32'h00);
        chk("rst.valid", 32'(rx.rx_valid), 0);
        chk("rst.tout",  32'(rx.timeout_err), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Sub-threshold glitch while idle
        glitch();
        repeat (3 * FL) @(negedge clk);
        chk("idle_glitch.busy", 32'(rx.busy), 0);
        chk_counts("idle_glitch");

        // Good 0x1C
        send_frame(8'h1C, 1'b0, 1'b1, 99);
        e_valid = 1;
        chk_counts("f1c");
        chk("f1c.data", 32'(rx.rx_data), 32'h1C);
        chk("f1c.busy", 32'(rx.busy), 0);

        // Back-to-back 0xF0 then 0x1C
        send_frame(8'hF0, 1'b1, 1'b1, 99);
        e_valid = 2;
        chk("ff0.data", 32'(rx.rx_data), 32'hF0);
        send_frame(8'h1C, 1'b0, 1'b1, 99);
        e_valid = 3;
        chk("b2b.data", 32'(rx.rx_data), 32'h1C);
        chk_counts("b2b");

        // 0xF0 then 0x1C with bad parity: data must hold at 0xF0
        send_frame(8'hF0, 1'b1, 1'b1, 99);
        e_valid = 4;
        send_frame(8'h1C, 1'b1, 1'b1, 99);
        e_perr = 1;
        chk_counts("perr");
        chk("perr.data", 32'(rx.rx_data), 32'hF0);

        // 0x1C with stop 0 (parity also bad), then good 0x32
        send_frame(8'h1C, 1'b1, 1'b0, 99);
        e_ferr = 1;
        chk_counts("stop0");
        chk("stop0.data", 32'(rx.rx_data), 32'hF0);
        send_frame(8'h32, 1'b0, 1'b1, 99);
        e_valid = 5;
        chk("f32.data", 32'(rx.rx_data), 32'h32);
        chk_counts("f32");

        // Bad start bit
        send_bit(1'b1);
        repeat (HP) @(negedge clk);
        e_ferr = 2;
        chk_counts("start1");
        chk("start1.busy", 32'(rx.busy), 0);

        // Sub-threshold glitch mid-frame must not add a bit
        send_frame(8'h1C, 1'b0, 1'b1, 2);
        e_valid = 6;
        chk("midglitch.data", 32'(rx.rx_data), 32'h1C);
        chk_counts("midglitch");

        // Timeout: start + 4 data bits, fifth edge timed by hand
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        @(negedge clk);
        kdata = 1'b1;
        repeat (HP) @(negedge clk);
        kclk = 1'b0;
        for (int k = 1; k <= 3 + FL + TO + 2; k++) begin
            @(negedge clk);
            if (k == HP) kclk = 1'b1;
            if (k == HP) chk("tout.busy_mid", 32'(rx.busy), 1);
            if (k == 2 + FL + TO) chk("tout.early", 32'(rx.timeout_err), 0);
            if (k == 3 + FL + TO) chk("tout.edge", 32'(rx.timeout_err), 1);
        end
        e_tout = 1;
        chk_counts("tout");
        chk("tout.busy", 32'(rx.busy), 0);
        send_frame(8'h32, 1'b0, 1'b1, 99);
        e_valid = 7;
        chk("after_tout.data", 32'(rx.rx_data), 32'h32);
        chk_counts("after_tout");

        // Reset mid-frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("midrst.busy_pre", 32'(rx.busy), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", 32'(rx.busy), 0);
        chk("midrst.data", 32'(rx.rx_data), 32'h00);
        chk("midrst.valid", 32'(rx.rx_valid), 0);
        kdata = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'hF0, 1'b1, 1'b1, 99);
        e_valid = 8;
        chk("after_rst.data", 32'(rx.rx_data), 32'hF0);
        chk_counts("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
